load_store_unit: RTL

Sits directly downstream of the single-cycle datapath, between its ALUResult/WriteData outputs and a data memory with a ready handshake. Converts each load/store into one word-aligned memory transaction with byte strobes. Returns sign/zero-extended ReadData to the datapath and asserts Stall until the access completes. Detects misaligned accesses and bus timeouts.

---
 rtl/load_store_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Turns datapath load/store requests into word-aligned memory
//            transactions with byte strobes, extends load data, flags faults.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MisalignedFault,
    output logic        BusError,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam int c_CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = (TIMEOUT == 0) ? '0 : c_CNT_W'(TIMEOUT - 1);

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [1:0]          r_off;
    logic [2:0]          r_funct3;
    logic [31:0]         r_rdata;
    logic                r_mis;
    logic                r_bus;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [31:0]         r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic [3:0]          r_mem_wstrb;

    logic                w_req;
    logic                w_byte;
    logic                w_half;
    logic                w_misaligned;
    logic [3:0]          w_wstrb;
    logic [31:0]         w_wdata;
    logic [31:0]         w_lane;
    logic [31:0]         w_load_ext;
    logic                w_timeout;

    // funct3[1:0] selects size; 011/110/111 fall into the word case
    assign w_req  = MemRead | MemWrite;
    assign w_byte = (funct3[1:0] == 2'b00);
    assign w_half = (funct3[1:0] == 2'b01);

    always_comb begin
        w_misaligned = 1'b0;
        w_wstrb      = 4'b1111;
        w_wdata      = WriteData;
        if (w_byte) begin
            w_wstrb = 4'b0001 << ALUResult[1:0];
            w_wdata = {4{WriteData[7:0]}};
        end else if (w_half) begin
            w_misaligned = ALUResult[0];
            w_wstrb      = 4'b0011 << ALUResult[1:0];
            w_wdata      = {2{WriteData[15:0]}};
        end else begin
            w_misaligned = (ALUResult[1:0] != 2'b00);
        end
    end

    assign w_lane = mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load_ext = w_lane;
        if (r_funct3[1:0] == 2'b00) begin
            w_load_ext = r_funct3[2] ? {24'd0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
        end else if (r_funct3[1:0] == 2'b01) begin
            w_load_ext = r_funct3[2] ? {16'd0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
        end
    end

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_off       <= 2'b00;
            r_funct3    <= 3'b000;
            r_rdata     <= 32'd0;
            r_mis       <= 1'b0;
            r_bus       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_wstrb <= 4'b0000;
        end else begin
            r_mis <= 1'b0;
            r_bus <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_req) begin
                        if (w_misaligned) begin
                            r_state <= S_FAULT;
                            r_mis   <= 1'b1;
                            r_rdata <= 32'd0;
                        end else begin
                            r_state     <= S_REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= MemWrite;
                            r_mem_addr  <= {ALUResult[31:2], 2'b00};
                            r_mem_wdata <= w_wdata;
                            r_mem_wstrb <= MemWrite ? w_wstrb : 4'b0000;
                            r_off       <= ALUResult[1:0];
                            r_funct3    <= funct3;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_DONE;
                        if (!r_mem_we) begin
                            r_rdata <= w_load_ext;
                        end
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_bus     <= 1'b1;
                        r_rdata   <= 32'd0;
                        r_state   <= S_FAULT;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_FAULT: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stall is gated by reset so an aborted access releases the pipeline at once
    assign Stall = reset && (((r_state == S_IDLE) && w_req) || (r_state == S_REQ));

    assign ReadData        = r_rdata;
    assign MisalignedFault = r_mis;
    assign BusError        = r_bus;
    assign mem_req         = r_mem_req;
    assign mem_we          = r_mem_we;
    assign mem_addr        = r_mem_addr;
    assign mem_wdata       = r_mem_wdata;
    assign mem_wstrb       = r_mem_wstrb;

endmodule
`default_nettype wire
